// File: rtl/mbist_wb_bridge.sv
// mbist_wb_bridge: burst Wishbone-style port onto a bank of BIST SRAMs, with
// latency-hiding read prefetch and sequential addressing across SRAM boundaries.
module mbist_wb_bridge #(
    parameter int BIST_NO_SRAM = 4,
    parameter int BIST_ADDR_WD = 9,
    parameter int BIST_DATA_WD = 32,
    parameter int MEM_RD_LAT   = 2,
    parameter int CS_WD        = $clog2(BIST_NO_SRAM)
) (
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [BIST_ADDR_WD-1:0]   wb_adr_i,
    input  logic [CS_WD-1:0]          wb_cs_i,
    input  logic [BIST_DATA_WD-1:0]   wb_dat_i,
    input  logic [BIST_DATA_WD/8-1:0] wb_sel_i,
    input  logic [9:0]                wb_bl_i,
    input  logic                      wb_bry_i,
    output logic [BIST_DATA_WD-1:0]   wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_lack_o,
    output logic                      wb_err_o,
    output logic                      mem_req,
    output logic [CS_WD-1:0]          mem_cs,
    output logic [BIST_ADDR_WD-1:0]   mem_addr,
    output logic                      mem_we,
    output logic [BIST_DATA_WD/8-1:0] mem_wmask,
    output logic [BIST_DATA_WD-1:0]   mem_wdata,
    input  logic [BIST_DATA_WD-1:0]   mem_rdata
);
    localparam int FD = MEM_RD_LAT + 1;
    localparam int FW = $clog2(FD + 1);
    localparam int AW = $clog2(FD);
    localparam logic [AW-1:0] FLAST = AW'(FD - 1);
    localparam logic [CS_WD:0] NSRAM = (CS_WD + 1)'(BIST_NO_SRAM);
    localparam logic [CS_WD-1:0] LAST_CS = CS_WD'(BIST_NO_SRAM - 1);
    localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2, ERROR = 2'd3;
    logic [1:0]              state;
    logic [CS_WD-1:0]        ptr_cs, nxt_cs;
    logic [BIST_ADDR_WD-1:0] ptr_addr;
    logic [9:0]              blen, issued, beats;
    logic [FW-1:0]           pend, fcnt;
    logic [FW:0]             used;
    logic [AW-1:0]           rd_ptr, wr_ptr;
    logic [MEM_RD_LAT-1:0]   rd_sr;
    logic [BIST_DATA_WD-1:0] fifo [2**AW];
    logic [BIST_DATA_WD-1:0] head;
    logic accept, bad_req, cap, avail, wr_beat, rd_beat, last_beat, issue, push, pop;
    assign accept    = state == IDLE && wb_stb_i && wb_bry_i && !wb_lack_o;
    assign bad_req   = {1'b0, wb_cs_i} >= NSRAM || wb_bl_i == '0;
    // rd_sr tracks each read from the cycle after mem_req until its data is valid
    assign cap       = rd_sr[MEM_RD_LAT-1];
    assign avail     = cap || fcnt != '0;
    assign wr_beat   = state == WRITE && wb_stb_i && wb_bry_i;
    assign rd_beat   = state == READ && wb_stb_i && wb_bry_i && avail;
    assign last_beat = beats + 10'd1 == blen;
    // an empty FIFO lets arriving data bypass straight to the bus
    assign head      = fcnt != '0 ? fifo[rd_ptr] : mem_rdata;
    assign push      = cap && !(rd_beat && fcnt == '0);
    assign pop       = rd_beat && fcnt != '0;
    // a credit freed by this cycle's beat may be reused at once, sustaining one beat per cycle
    assign used      = {1'b0, pend} + {1'b0, fcnt} - (FW + 1)'(rd_beat);
    assign issue     = state == READ && issued != blen && used < (FW + 1)'(FD);
    assign nxt_cs    = &ptr_addr ? (ptr_cs == LAST_CS ? '0 : ptr_cs + 1'b1) : ptr_cs;
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo[wr_ptr] <= mem_rdata;
    end
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr_cs    <= '0;
            ptr_addr  <= '0;
            blen      <= '0;
            issued    <= '0;
            beats     <= '0;
            pend      <= '0;
            fcnt      <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rd_sr     <= '0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_lack_o <= 1'b0;
            wb_err_o  <= 1'b0;
            mem_req   <= 1'b0;
            mem_cs    <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else begin
            rd_sr <= MEM_RD_LAT'({rd_sr, mem_req & ~mem_we});
            pend  <= pend + FW'(issue) - FW'(cap);
            fcnt  <= fcnt + FW'(push) - FW'(pop);
            if (push) wr_ptr <= wr_ptr == FLAST ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == FLAST ? '0 : rd_ptr + 1'b1;
            case (state)
                IDLE: begin
                    wb_ack_o  <= 1'b0;
                    wb_lack_o <= 1'b0;
                    wb_err_o  <= 1'b0;
                    mem_req   <= 1'b0;
                    if (accept) begin
                        ptr_cs   <= wb_cs_i;
                        ptr_addr <= wb_adr_i;
                        blen     <= wb_bl_i;
                        issued   <= '0;
                        beats    <= '0;
                        if (bad_req) begin
                            state     <= ERROR;
                            wb_err_o  <= 1'b1;
                            wb_lack_o <= 1'b1;
                        end else begin
                            state <= wb_we_i ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    mem_req  <= wr_beat;
                    wb_ack_o <= wr_beat;
                    if (wr_beat) begin
                        mem_we    <= 1'b1;
                        mem_cs    <= ptr_cs;
                        mem_addr  <= ptr_addr;
                        mem_wdata <= wb_dat_i;
                        mem_wmask <= wb_sel_i;
                        ptr_cs    <= nxt_cs;
                        ptr_addr  <= ptr_addr + 1'b1;
                        beats     <= beats + 10'd1;
                        if (last_beat) begin
                            wb_lack_o <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                READ: begin
                    mem_req  <= issue;
                    wb_ack_o <= rd_beat;
                    if (issue) begin
                        mem_we   <= 1'b0;
                        mem_cs   <= ptr_cs;
                        mem_addr <= ptr_addr;
                        ptr_cs   <= nxt_cs;
                        ptr_addr <= ptr_addr + 1'b1;
                        issued   <= issued + 10'd1;
                    end
                    if (rd_beat) begin
                        wb_dat_o <= head;
                        beats    <= beats + 10'd1;
                        if (last_beat) begin
                            wb_lack_o <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                ERROR: begin
                    wb_err_o  <= 1'b0;
                    wb_lack_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
